// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch state encodings and default widths
package fetch_unit_pkg;
  localparam int PC_W_DEF = 8;
  localparam int INSTR_W_DEF = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry {instr,pc} holding register for fetches the IQ refused
module fetch_skid_buffer #(
  parameter int INSTR_W = 32,
  parameter int PC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= in_instr;
      pc <= in_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order fetch front end owning the PC and feeding the IQ without loss or duplication
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    im_addr,
  input  logic [INSTR_W-1:0] im_data,
  input  logic               iq_full,
  output logic               iq_enqueue,
  output logic [INSTR_W-1:0] iq_instr,
  output logic [PC_W-1:0]    iq_pc,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    PC
);
  logic [PC_W-1:0] pc_q, inflight_pc, skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic [1:0] state_q, state_d;
  logic inflight, skid_v, fetch_en, out_v, skid_load, skid_drain;
  // S_RUN is exactly "a fetch is in flight", so the state register doubles as the inflight flag
  always_comb begin
    inflight = state_q == S_RUN;
    fetch_en = !redirect && !iq_full && !skid_v;
    out_v = skid_v || inflight;
    skid_load = inflight && !skid_v && iq_full && !redirect;
    skid_drain = skid_v && !iq_full && !redirect;
    state_d = redirect ? S_IDLE : (skid_load || (skid_v && iq_full)) ? S_HOLD : fetch_en ? S_RUN : S_IDLE;
    iq_enqueue = out_v && !iq_full && !redirect;
    iq_instr = skid_v ? skid_instr : inflight ? im_data : '0;
    iq_pc = skid_v ? skid_pc : inflight ? inflight_pc : '0;
    im_addr = pc_q;
    PC = pc_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q <= PC_W'(RESET_PC);
      inflight_pc <= '0;
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
      if (redirect) pc_q <= redirect_pc;
      else if (fetch_en) begin
        pc_q <= pc_q + 1'b1;
        inflight_pc <= pc_q;
      end
    end
  fetch_skid_buffer #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u_skid (
    .clk(clk),
    .rst_n(rst_n),
    .load(skid_load),
    .drain(skid_drain),
    .clear(redirect),
    .in_instr(im_data),
    .in_pc(inflight_pc),
    .valid(skid_v),
    .instr(skid_instr),
    .pc(skid_pc)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus reset and random scoreboard checks for fetch_unit
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] im_addr;
  logic [31:0] im_data = '0;
  logic iq_full = 1'b0;
  logic iq_enqueue;
  logic [31:0] iq_instr;
  logic [7:0] iq_pc;
  logic redirect = 1'b0;
  logic [7:0] redirect_pc = '0;
  logic [7:0] PC;
  logic [31:0] mem [256];
  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_data(im_data),
    .iq_full(iq_full), .iq_enqueue(iq_enqueue), .iq_instr(iq_instr), .iq_pc(iq_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .PC(PC)
  );

  always #5 clk = ~clk;
  always @(posedge clk) im_data <= mem[im_addr];

  typedef struct {
    logic full;
    logic redir;
    logic [7:0] rpc;
    logic enq;
    logic [7:0] pc;
    logic [7:0] fpc;
  } vec_t;

  vec_t vecs [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic full, input logic redir, input logic [7:0] rpc);
    @(negedge clk);
    iq_full = full;
    redirect = redir;
    redirect_pc = rpc;
    #1;
  endtask

  initial begin
    logic [7:0] exp_next;
    int n_enq;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    vecs = '{
      '{0,0,8'h00, 0,8'h00,8'h00}, '{0,0,8'h00, 1,8'h00,8'h01}, '{0,0,8'h00, 1,8'h01,8'h02},
      '{0,0,8'h00, 1,8'h02,8'h03}, '{0,0,8'h00, 1,8'h03,8'h04}, '{0,0,8'h00, 1,8'h04,8'h05},
      '{1,0,8'h00, 0,8'h00,8'h06}, '{1,0,8'h00, 0,8'h00,8'h06}, '{1,0,8'h00, 0,8'h00,8'h06},
      '{0,0,8'h00, 1,8'h05,8'h06}, '{0,0,8'h00, 0,8'h00,8'h06}, '{0,0,8'h00, 1,8'h06,8'h07},
      '{0,0,8'h00, 1,8'h07,8'h08}, '{1,0,8'h00, 0,8'h00,8'h09}, '{0,1,8'h40, 0,8'h00,8'h09},
      '{0,0,8'h00, 0,8'h00,8'h40}, '{0,0,8'h00, 1,8'h40,8'h41}, '{0,1,8'hFE, 0,8'h00,8'h42},
      '{0,0,8'h00, 0,8'h00,8'hFE}, '{0,0,8'h00, 1,8'hFE,8'hFF}, '{0,0,8'h00, 1,8'hFF,8'h00},
      '{0,0,8'h00, 1,8'h00,8'h01}, '{0,0,8'h00, 1,8'h01,8'h02}
    };
    repeat (2) @(negedge clk);
    #1;
    chk("reset_enq", 32'(iq_enqueue), 0);
    chk("reset_pc", 32'(PC), 0);
    chk("reset_iq_pc", 32'(iq_pc), 0);
    chk("reset_iq_instr", iq_instr, 0);
    @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = 1'b1;
      iq_full = vecs[i].full;
      redirect = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      #1;
      chk($sformatf("v%0d_enq", i), 32'(iq_enqueue), 32'(vecs[i].enq));
      chk($sformatf("v%0d_PC", i), 32'(PC), 32'(vecs[i].fpc));
      if (vecs[i].enq) begin
        chk($sformatf("v%0d_iq_pc", i), 32'(iq_pc), 32'(vecs[i].pc));
        chk($sformatf("v%0d_iq_instr", i), iq_instr, 32'(vecs[i].pc));
      end
    end
    drive(1, 0, 0);
    chk("pre_rst_stall_enq", 32'(iq_enqueue), 0);
    @(negedge clk);
    iq_full = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_enq", 32'(iq_enqueue), 0);
    chk("midrst_PC", 32'(PC), 0);
    chk("midrst_iq_pc", 32'(iq_pc), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_enq", 32'(iq_enqueue), 0);
    chk("rel_PC", 32'(PC), 0);
    drive(0, 0, 0);
    chk("restart_enq", 32'(iq_enqueue), 1);
    chk("restart_iq_pc", 32'(iq_pc), 0);
    chk("restart_PC", 32'(PC), 1);
    exp_next = 8'h01;
    n_enq = 0;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, 8'($urandom));
      if (redirect) begin
        chk("rnd_redirect_enq", 32'(iq_enqueue), 0);
        exp_next = redirect_pc;
      end else if (iq_full) begin
        chk("rnd_full_enq", 32'(iq_enqueue), 0);
      end else if (iq_enqueue) begin
        chk("rnd_iq_pc", 32'(iq_pc), 32'(exp_next));
        chk("rnd_iq_instr", iq_instr, 32'(exp_next));
        exp_next = exp_next + 8'd1;
        n_enq++;
      end
    end
    chk("rnd_progress", 32'(n_enq > 100), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
